// File: rtl/ct_idu_rf_pipe6_srcv_buf.sv
// Purpose : 2-entry in-order operand buffer between the RF stage and VFPU EX1 for pipe6.
// Latency : 1 cycle from RF acceptance to EX1 launch when the buffer is empty.
// Backpr. : idu_rf_pipe6_ready drops when both entries are full; EX1 stalls hold the head stable.
//
// Ports:
//   forever_cpuclk / cpurst              clock, asynchronous active-high reset
//   rtu_yy_xx_flush                      kills buffered and incoming instructions
//   rf_pipe6_vld/_iid/_dstv_reg          RF-stage instruction
//   rf_pipe6_srcvN_rf_data/_fwd_data/_no_fwd   per-source operand candidates
//   idu_rf_pipe6_ready                   buffer can accept this cycle
//   vfpu_ex1_pipe6_ready                 EX1 consumes the head entry this cycle
//   idu_vfpu_ex1_pipe6_*                 head-entry launch to EX1
// Optional third source operand is enabled by defining VFPU_PIPE6_SRCV2_EN.

module ct_idu_rf_pipe6_srcv_buf (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        rtu_yy_xx_flush,
  input  logic        rf_pipe6_vld,
  input  logic [6:0]  rf_pipe6_iid,
  input  logic [6:0]  rf_pipe6_dstv_reg,
  input  logic [63:0] rf_pipe6_srcv0_rf_data,
  input  logic [63:0] rf_pipe6_srcv0_fwd_data,
  input  logic        rf_pipe6_srcv0_no_fwd,
  input  logic [63:0] rf_pipe6_srcv1_rf_data,
  input  logic [63:0] rf_pipe6_srcv1_fwd_data,
  input  logic        rf_pipe6_srcv1_no_fwd,
`ifdef VFPU_PIPE6_SRCV2_EN
  input  logic [63:0] rf_pipe6_srcv2_rf_data,
  input  logic [63:0] rf_pipe6_srcv2_fwd_data,
  input  logic        rf_pipe6_srcv2_no_fwd,
  output logic [63:0] idu_vfpu_ex1_pipe6_srcv2,
`endif
  output logic        idu_rf_pipe6_ready,
  input  logic        vfpu_ex1_pipe6_ready,
  output logic        idu_vfpu_ex1_pipe6_vld,
  output logic [6:0]  idu_vfpu_ex1_pipe6_iid,
  output logic [6:0]  idu_vfpu_ex1_pipe6_dstv_reg,
  output logic [63:0] idu_vfpu_ex1_pipe6_srcv0,
  output logic [63:0] idu_vfpu_ex1_pipe6_srcv1
);

  typedef struct packed {
    logic [6:0]  iid;
    logic [6:0]  dstv_reg;
`ifdef VFPU_PIPE6_SRCV2_EN
    logic [63:0] srcv2;
`endif
    logic [63:0] srcv1;
    logic [63:0] srcv0;
  } ent_t;

  // r_ent0 is always the head; r_ent1 is only meaningful when r_cnt == 2.
  ent_t       r_ent0;
  ent_t       r_ent1;
  logic [1:0] r_cnt;

  ent_t       w_new;
  logic       w_push;
  logic       w_pop;
  logic       w_vld;
  logic       w_ready;

  assign w_vld   = (r_cnt != 2'd0);
  assign w_ready = (r_cnt != 2'd2);
  assign w_push  = rf_pipe6_vld && w_ready && !rtu_yy_xx_flush;
  assign w_pop   = w_vld && vfpu_ex1_pipe6_ready && !rtu_yy_xx_flush;

  // Forward data is only valid in the RF cycle, so the selected operand is
  // frozen into the entry at acceptance time.
  always_comb begin
    w_new          = '0;
    w_new.iid      = rf_pipe6_iid;
    w_new.dstv_reg = rf_pipe6_dstv_reg;
    w_new.srcv0    = rf_pipe6_srcv0_no_fwd ? rf_pipe6_srcv0_rf_data : rf_pipe6_srcv0_fwd_data;
    w_new.srcv1    = rf_pipe6_srcv1_no_fwd ? rf_pipe6_srcv1_rf_data : rf_pipe6_srcv1_fwd_data;
`ifdef VFPU_PIPE6_SRCV2_EN
    w_new.srcv2    = rf_pipe6_srcv2_no_fwd ? rf_pipe6_srcv2_rf_data : rf_pipe6_srcv2_fwd_data;
`endif
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_cnt  <= 2'd0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else if (rtu_yy_xx_flush) begin
      // Payload is left as-is; it is invisible once the count is zero.
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= w_new;
          else               r_ent1 <= w_new;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Push is blocked at count 2, so this is the count-1 case:
          // the incoming entry replaces the departing head directly.
          if (r_cnt == 2'd1) begin
            r_ent0 <= w_new;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign idu_rf_pipe6_ready          = w_ready;
  assign idu_vfpu_ex1_pipe6_vld      = w_vld;
  assign idu_vfpu_ex1_pipe6_iid      = r_ent0.iid;
  assign idu_vfpu_ex1_pipe6_dstv_reg = r_ent0.dstv_reg;
  assign idu_vfpu_ex1_pipe6_srcv0    = r_ent0.srcv0;
  assign idu_vfpu_ex1_pipe6_srcv1    = r_ent0.srcv1;
`ifdef VFPU_PIPE6_SRCV2_EN
  assign idu_vfpu_ex1_pipe6_srcv2    = r_ent0.srcv2;
`endif

endmodule

// File: tb/tb_ct_idu_rf_pipe6_srcv_buf.sv
// Bench for ct_idu_rf_pipe6_srcv_buf: directed scenarios followed by a random
// traffic phase, all checked against a queue-based model of the buffer.
module tb_ct_idu_rf_pipe6_srcv_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        vld;
  logic [6:0]  iid;
  logic [6:0]  dst;
  logic [63:0] s0_rf, s0_fwd, s1_rf, s1_fwd;
  logic        s0_nf, s1_nf;
`ifdef VFPU_PIPE6_SRCV2_EN
  logic [63:0] s2_rf, s2_fwd, o_s2;
  logic        s2_nf;
`endif
  logic        o_ready;
  logic        ex1_rdy;
  logic        o_vld;
  logic [6:0]  o_iid, o_dst;
  logic [63:0] o_s0, o_s1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  iid;
    logic [6:0]  dst;
    logic [63:0] s0;
    logic [63:0] s1;
`ifdef VFPU_PIPE6_SRCV2_EN
    logic [63:0] s2;
`endif
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  ct_idu_rf_pipe6_srcv_buf dut (
    .forever_cpuclk              (clk),
    .cpurst                      (rst),
    .rtu_yy_xx_flush             (flush),
    .rf_pipe6_vld                (vld),
    .rf_pipe6_iid                (iid),
    .rf_pipe6_dstv_reg           (dst),
    .rf_pipe6_srcv0_rf_data      (s0_rf),
    .rf_pipe6_srcv0_fwd_data     (s0_fwd),
    .rf_pipe6_srcv0_no_fwd       (s0_nf),
    .rf_pipe6_srcv1_rf_data      (s1_rf),
    .rf_pipe6_srcv1_fwd_data     (s1_fwd),
    .rf_pipe6_srcv1_no_fwd       (s1_nf),
`ifdef VFPU_PIPE6_SRCV2_EN
    .rf_pipe6_srcv2_rf_data      (s2_rf),
    .rf_pipe6_srcv2_fwd_data     (s2_fwd),
    .rf_pipe6_srcv2_no_fwd       (s2_nf),
    .idu_vfpu_ex1_pipe6_srcv2    (o_s2),
`endif
    .idu_rf_pipe6_ready          (o_ready),
    .vfpu_ex1_pipe6_ready        (ex1_rdy),
    .idu_vfpu_ex1_pipe6_vld      (o_vld),
    .idu_vfpu_ex1_pipe6_iid      (o_iid),
    .idu_vfpu_ex1_pipe6_dstv_reg (o_dst),
    .idu_vfpu_ex1_pipe6_srcv0    (o_s0),
    .idu_vfpu_ex1_pipe6_srcv1    (o_s1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the buffer.
  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 64'(o_ready), 64'(q.size() != 2));
    chk({tag, ".vld"},   64'(o_vld),   64'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".iid"}, 64'(o_iid), 64'(q[0].iid));
      chk({tag, ".dst"}, 64'(o_dst), 64'(q[0].dst));
      chk({tag, ".s0"},  o_s0, q[0].s0);
      chk({tag, ".s1"},  o_s1, q[0].s1);
`ifdef VFPU_PIPE6_SRCV2_EN
      chk({tag, ".s2"},  o_s2, q[0].s2);
`endif
    end
  endtask

  // One clock: decide the model's events from the inputs held before the edge,
  // then apply them and check the DUT 1 time unit after the edge.
  task automatic cycle(input string tag);
    ent_t e;
    bit   push, pop;
    push  = vld && (q.size() != 2) && !flush;
    pop   = (q.size() != 0) && ex1_rdy && !flush;
    e.iid = iid;
    e.dst = dst;
    e.s0  = s0_nf ? s0_rf : s0_fwd;
    e.s1  = s1_nf ? s1_rf : s1_fwd;
`ifdef VFPU_PIPE6_SRCV2_EN
    e.s2  = s2_nf ? s2_rf : s2_fwd;
`endif
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    check_model(tag);
  endtask

  task automatic rand_operands();
    s0_rf  = {$urandom, $urandom};
    s0_fwd = {$urandom, $urandom};
    s1_rf  = {$urandom, $urandom};
    s1_fwd = {$urandom, $urandom};
    s0_nf  = 1'($urandom);
    s1_nf  = 1'($urandom);
    dst    = 7'($urandom);
`ifdef VFPU_PIPE6_SRCV2_EN
    s2_rf  = {$urandom, $urandom};
    s2_fwd = {$urandom, $urandom};
    s2_nf  = 1'($urandom);
`endif
  endtask

  task automatic send(input logic [6:0] id, input bit rdy, input string tag);
    rand_operands();
    vld = 1'b1; iid = id; ex1_rdy = rdy; flush = 1'b0;
    cycle(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vld = 1'b0; iid = '0; ex1_rdy = 1'b0;
    rand_operands();
    #1;
    chk("reset.vld",   64'(o_vld),   64'd0);
    chk("reset.ready", 64'(o_ready), 64'd1);
    chk("reset.s0",    o_s0,         64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_model("idle");

    // Operand selection: source 0 from RF, source 1 from forward network.
    vld = 1'b1; iid = 7'd9; dst = 7'd4; ex1_rdy = 1'b1;
    s0_nf = 1'b1; s0_rf = 64'h11; s0_fwd = 64'hdead;
    s1_nf = 1'b0; s1_rf = 64'hbeef; s1_fwd = 64'h22;
    cycle("sel");
    chk("sel.vld", 64'(o_vld), 64'd1);
    chk("sel.s0",  o_s0, 64'h11);
    chk("sel.s1",  o_s1, 64'h22);
    vld = 1'b0;
    cycle("sel_drain");

    // Back-to-back with EX1 stalled: iid 3 must wait upstream.
    send(7'd1, 1'b0, "b2b1");
    send(7'd2, 1'b0, "b2b2");
    chk("b2b.ready_low", 64'(o_ready), 64'd0);
    send(7'd3, 1'b0, "b2b3_held");
    chk("b2b.head1", 64'(o_iid), 64'd1);
    ex1_rdy = 1'b1;
    cycle("b2b_rel1");
    chk("b2b.head2", 64'(o_iid), 64'd2);
    cycle("b2b_rel2");
    chk("b2b.head3", 64'(o_iid), 64'd3);
    vld = 1'b0;
    cycle("b2b_drain");
    chk("b2b.empty", 64'(o_vld), 64'd0);

    // Simultaneous push/pop at count 1.
    send(7'd4, 1'b0, "pp_fill");
    send(7'd5, 1'b1, "pp");
    chk("pp.head5", 64'(o_iid), 64'd5);
    chk("pp.vld",   64'(o_vld), 64'd1);
    vld = 1'b0;
    cycle("pp_drain");

    // Flush at count 2 with an incoming instruction.
    send(7'd6, 1'b0, "fl_a");
    send(7'd7, 1'b0, "fl_b");
    vld = 1'b1; iid = 7'd8; flush = 1'b1;
    cycle("flush");
    chk("flush.vld",   64'(o_vld),   64'd0);
    chk("flush.ready", 64'(o_ready), 64'd1);
    vld = 1'b0; flush = 1'b0;
    cycle("flush_after");
    chk("flush.nocap", 64'(o_vld), 64'd0);

    // Forward data changes while the head stalls.
    vld = 1'b1; iid = 7'd10; ex1_rdy = 1'b0;
    s0_nf = 1'b0; s0_fwd = 64'h1234; s1_nf = 1'b0; s1_fwd = 64'h5678;
    cycle("stall_in");
    vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_operands();
      cycle("stall_hold");
    end
    chk("stall.s0", o_s0, 64'h1234);
    chk("stall.s1", o_s1, 64'h5678);

    // Asynchronous reset during a full stall.
    send(7'd11, 1'b0, "rst_fill");
    chk("rst.full", 64'(o_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("rst.vld",   64'(o_vld),   64'd0);
    chk("rst.ready", 64'(o_ready), 64'd1);
    chk("rst.iid",   64'(o_iid),   64'd0);
    chk("rst.s0",    o_s0,         64'd0);
    chk("rst.s1",    o_s1,         64'd0);
    #2 rst = 1'b0;
    vld = 1'b0;
    cycle("rst_after");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rand_operands();
      vld     = ($urandom_range(0, 9) < 7);
      iid     = 7'($urandom);
      ex1_rdy = ($urandom_range(0, 9) < 5);
      flush   = ($urandom_range(0, 99) < 5);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_idu_rf_pipe6_srcv_buf.md
CT_IDU_RF_PIPE6_SRCV_BUF -- requirements
Module: ct_idu_rf_pipe6_srcv_buf

Interface
REQ-001 SHALL have port forever_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port cpurst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port rtu_yy_xx_flush  in  1  pipeline flush; kills all buffered and incoming operands.
REQ-004 SHALL have port rf_pipe6_vld  in  1  RF-stage instruction valid for pipe6.
REQ-005 SHALL have port rf_pipe6_iid  in  7  instruction id.
REQ-006 SHALL have port rf_pipe6_dstv_reg  in  7  destination vreg.
REQ-007 SHALL have port rf_pipe6_srcv0_rf_data  in  64  source 0 register-file read data.
REQ-008 SHALL have port rf_pipe6_srcv0_fwd_data  in  64  source 0 forward-network data (x_srcv_data of a forward-select instance).
REQ-009 SHALL have port rf_pipe6_srcv0_no_fwd  in  1  source 0 has no forward hit (x_srcv_no_fwd).
REQ-010 SHALL have ports rf_pipe6_srcv1_rf_data / _fwd_data / _no_fwd  in  64/64/1  same as REQ-007..009 for source 1.
REQ-011 SHALL have port idu_rf_pipe6_ready  out  1  buffer accepts an RF instruction this cycle.
REQ-012 SHALL have port vfpu_ex1_pipe6_ready  in  1  EX1 consumes head entry this cycle.
REQ-013 SHALL have ports idu_vfpu_ex1_pipe6_vld / _iid / _dstv_reg / _srcv0 / _srcv1  out  1/7/7/64/64  head-entry launch to EX1.

Function
REQ-014 SHALL hold a 2-entry in-order FIFO; each entry stores iid, dstv_reg, srcv0, srcv1.
REQ-015 SHALL capture per source: data = no_fwd ? rf_data : fwd_data, sampled in the accepting cycle only (forward data is transient).
REQ-016 SHALL push when rf_pipe6_vld && idu_rf_pipe6_ready && !rtu_yy_xx_flush.
REQ-017 SHALL pop when idu_vfpu_ex1_pipe6_vld && vfpu_ex1_pipe6_ready && !rtu_yy_xx_flush.
REQ-018 SHALL drive idu_rf_pipe6_ready = (count != 2), combinationally from registered count only.
REQ-019 SHALL drive idu_vfpu_ex1_pipe6_vld = (count != 0); payload outputs from head entry, registered, no input-to-output combinational path.
REQ-020 SHALL give latency 1: instruction accepted in cycle N is visible at EX1 outputs in N+1 when FIFO was empty.
REQ-021 SHALL on simultaneous push and pop with count 1: new entry becomes head, count stays 1.
REQ-022 SHALL keep count in 0..2; pop at count 0 and push at count 2 impossible by construction.
REQ-023 SHALL on rtu_yy_xx_flush: count = 0 next cycle, incoming push and pop both suppressed; flush has priority over all events.
REQ-024 SHALL keep head outputs stable while vld && !vfpu_ex1_pipe6_ready (no payload change during stall).

Reset
REQ-025 SHALL on cpurst asynchronously clear count to 0, idu_vfpu_ex1_pipe6_vld to 0, idu_rf_pipe6_ready to 1.
REQ-026 SHALL reset payload registers to 0; reset asserted mid-stall discards all entries.

Configuration
REQ-027 SHALL support macro VFPU_PIPE6_SRCV2_EN: defined -> adds rf_pipe6_srcv2_rf_data/_fwd_data/_no_fwd inputs, idu_vfpu_ex1_pipe6_srcv2 output, and a srcv2 field per entry with REQ-015 selection; undefined -> these ports and storage absent, all other behaviour identical.

Verification
REQ-028 SHALL verify: empty, vld=1, srcv0 no_fwd=1 rf=0x11, srcv1 no_fwd=0 fwd=0x22, ex1_ready=1 -> next cycle vld=1, srcv0=0x11, srcv1=0x22.
REQ-029 SHALL verify: ex1_ready=0, three back-to-back vld with iid 1,2,3 -> ready drops after iid 2; iid 3 held upstream; release gives iid 1,2,3 in order.
REQ-030 SHALL verify: count 1, push iid 5 and pop same cycle -> count 1, head iid 5 next cycle.
REQ-031 SHALL verify: count 2 with rf_pipe6_vld=1 and flush=1 -> next cycle vld=0, ready=1, no entry captured.
REQ-032 SHALL verify: cpurst pulsed during stall with count 2 -> vld=0, ready=1 immediately, outputs 0.
REQ-033 SHALL verify: fwd_data changes while entry stalled -> held srcv outputs unchanged.
